// File: rtl/xbar_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xbar_slave_mem_pkg
// Brief    : Shared state encodings and command codes for the crossbar
//            RAM slave model.
// Revision : 1.0 - initial release
// ============================================================================
package xbar_slave_mem_pkg;

    // Slave FSM states; encodings are shared with the crossbar and other
    // slave models, so the values are pinned explicitly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic c_CMD_READ  = 1'b0;
    localparam logic c_CMD_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/xbar_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : xbar_slave_mem_if
// Brief    : One crossbar slave port: request/command/data from the master,
//            ack/read data/transaction count back from the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface xbar_slave_mem_if;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [15:0] txn_cnt;

    modport master (
        output req, addr, cmd, wdata,
        input  ack, rdata, txn_cnt
    );

    modport slave (
        input  req, addr, cmd, wdata,
        output ack, rdata, txn_cnt
    );
endinterface
`default_nettype wire

// File: rtl/xbar_slave_mem_sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : xbar_sp_ram
// Brief    : Single-port synchronous RAM, one-cycle read, write-first.
//            The read register only updates on a read, so it holds the last
//            read word across writes and idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_sp_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_we,
    input  wire logic          i_re,
    input  wire logic [AW-1:0] i_idx,
    input  wire logic [DW-1:0] i_wdata,
    output logic      [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Storage array: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read register: write-first when read and write coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_we ? i_wdata : r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/xbar_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : xbar_slave_mem
// Brief    : Word-addressed RAM slave on a crossbar slave port with
//            programmable wait states and a completed-transaction counter.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_slave_mem
    import xbar_slave_mem_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    xbar_slave_mem_if.slave bus
);

    // Counter preload: WAIT holds for WAIT_CYCLES cycles counting down to 0.
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic       c_NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          w_wait_cnt_nxt;
    logic [15:0]         r_txn_cnt;
    logic                w_we;
    logic                w_re;
    logic [MEM_AW-1:0]   w_idx;
    logic                w_unused_addr;

    // Bits [1:0] are byte lanes and upper bits alias; only the word index is used.
    assign w_idx         = bus.addr[MEM_AW+1:2];
    assign w_unused_addr = ^{bus.addr[31:MEM_AW+2], bus.addr[1:0]};

    // State, wait counter and transaction counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_txn_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (r_state == ST_ACK) begin
                r_txn_cnt <= r_txn_cnt + 16'd1;
            end
        end
    end

    // Next-state and RAM strobes; a request is accepted from IDLE or RESP.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_we           = 1'b0;
        w_re           = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (bus.req) begin
                    w_state_nxt    = c_NO_WAIT ? ST_ACK : ST_WAIT;
                    w_wait_cnt_nxt = c_WAIT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.req) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                if (bus.cmd == c_CMD_WRITE) begin
                    w_we        = !rst;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_re        = !rst;
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    xbar_sp_ram #(
        .AW (MEM_AW),
        .DW (32)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_idx),
        .i_wdata (bus.wdata),
        .o_rdata (bus.rdata)
    );

    assign bus.ack     = (r_state == ST_ACK);
    assign bus.txn_cnt = r_txn_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xbar_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_slave_mem
// Brief    : Directed self-checking bench for xbar_slave_mem; one instance
//            with two wait states and one with none.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_slave_mem;
    import xbar_slave_mem_pkg::*;

    logic clk = 1'b0;
    logic rst2;
    logic rst0;
    int   n_cmp = 0;
    int   n_mis = 0;

    xbar_slave_mem_if b2 ();
    xbar_slave_mem_if b0 ();

    xbar_slave_mem #(.MEM_AW(8), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk), .rst (rst2), .bus (b2.slave)
    );
    xbar_slave_mem #(.MEM_AW(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk), .rst (rst0), .bus (b0.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the 2-wait-state port. ack_cyc is the cycle index
    // (0 = first cycle req seen) in which ack appeared, -1 on timeout.
    task automatic txn2(input logic c, input logic [31:0] a, input logic [31:0] d,
                        output int ack_cyc, output logic ack_nxt, output logic [31:0] rd);
        @(posedge clk); #1;
        b2.req = 1'b1; b2.cmd = c; b2.addr = a; b2.wdata = d;
        ack_cyc = -1;
        for (int k = 0; k < 20 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (b2.ack) ack_cyc = k;
        end
        @(posedge clk); #1;
        b2.req = 1'b0;
        @(negedge clk);
        ack_nxt = b2.ack;
        rd      = b2.rdata;
    endtask

    // Same transaction shape on the zero-wait-state port.
    task automatic txn0(input logic c, input logic [31:0] a, input logic [31:0] d,
                        output int ack_cyc, output logic [31:0] rd);
        @(posedge clk); #1;
        b0.req = 1'b1; b0.cmd = c; b0.addr = a; b0.wdata = d;
        ack_cyc = -1;
        for (int k = 0; k < 20 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (b0.ack) ack_cyc = k;
        end
        @(posedge clk); #1;
        b0.req = 1'b0;
        @(negedge clk);
        rd = b0.rdata;
    endtask

    initial begin
        int          ac;
        logic        an;
        logic [31:0] rd;

        rst2 = 1'b1; rst0 = 1'b1;
        b2.req = 1'b0; b2.cmd = c_CMD_READ; b2.addr = '0; b2.wdata = '0;
        b0.req = 1'b0; b0.cmd = c_CMD_READ; b0.addr = '0; b0.wdata = '0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack2",   32'(b2.ack),     32'd0);
        chk("rst_rdata2", b2.rdata,        32'd0);
        chk("rst_txn2",   32'(b2.txn_cnt), 32'd0);
        chk("rst_ack0",   32'(b0.ack),     32'd0);
        chk("rst_rdata0", b0.rdata,        32'd0);
        chk("rst_txn0",   32'(b0.txn_cnt), 32'd0);
        @(posedge clk); #1;
        rst2 = 1'b0; rst0 = 1'b0;

        // Two wait states: write then read back
        txn2(c_CMD_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, ac, an, rd);
        chk("w2_ackcyc", 32'(ac), 32'd3);
        chk("w2_txn",    32'(b2.txn_cnt), 32'd1);
        txn2(c_CMD_READ, 32'h0000_0010, 32'h0, ac, an, rd);
        chk("r2_ackcyc", 32'(ac), 32'd3);
        chk("r2_pulse",  32'(an), 32'd0);
        chk("r2_rdata",  rd, 32'hDEAD_BEEF);
        chk("r2_txn",    32'(b2.txn_cnt), 32'd2);

        // Zero wait states: preload two words, then back-to-back reads
        txn0(c_CMD_WRITE, 32'h0000_0004, 32'h1111_1111, ac, rd);
        chk("w0a_ackcyc", 32'(ac), 32'd1);
        txn0(c_CMD_WRITE, 32'h0000_0008, 32'h2222_2222, ac, rd);
        chk("w0b_ackcyc", 32'(ac), 32'd1);
        @(posedge clk); #1;
        b0.req = 1'b1; b0.cmd = c_CMD_READ; b0.addr = 32'h0000_0004;
        @(negedge clk);                     // cycle 0: IDLE
        chk("b2b_c0_ack", 32'(b0.ack), 32'd0);
        @(negedge clk);                     // cycle 1: ACK
        chk("b2b_c1_ack", 32'(b0.ack), 32'd1);
        @(posedge clk); #1;
        b0.addr = 32'h0000_0008;
        @(negedge clk);                     // cycle 2: RESP
        chk("b2b_c2_ack",   32'(b0.ack), 32'd0);
        chk("b2b_c2_rdata", b0.rdata, 32'h1111_1111);
        @(negedge clk);                     // cycle 3: ACK again
        chk("b2b_c3_ack", 32'(b0.ack), 32'd1);
        @(posedge clk); #1;
        b0.req = 1'b0;
        @(negedge clk);                     // cycle 4: RESP
        chk("b2b_c4_ack",   32'(b0.ack), 32'd0);
        chk("b2b_c4_rdata", b0.rdata, 32'h2222_2222);
        chk("b2b_txn",      32'(b0.txn_cnt), 32'd4);

        // Abort: req drops while in WAIT
        txn2(c_CMD_WRITE, 32'h0000_0020, 32'hAAAA_5555, ac, an, rd);
        chk("ab_pre_txn", 32'(b2.txn_cnt), 32'd3);
        @(posedge clk); #1;
        b2.req = 1'b1; b2.cmd = c_CMD_WRITE; b2.addr = 32'h0000_0020; b2.wdata = 32'hBAD0_BAD0;
        @(negedge clk);                     // cycle 0
        @(negedge clk);                     // cycle 1: WAIT
        @(posedge clk); #1;
        b2.req = 1'b0;
        an = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            an = an | b2.ack;
        end
        chk("ab_noack", 32'(an), 32'd0);
        chk("ab_txn",   32'(b2.txn_cnt), 32'd3);
        txn2(c_CMD_READ, 32'h0000_0020, 32'h0, ac, an, rd);
        chk("ab_rdata", rd, 32'hAAAA_5555);
        chk("ab_post_txn", 32'(b2.txn_cnt), 32'd4);

        // Aliasing: bit 10 and byte offset are ignored with MEM_AW=8
        txn2(c_CMD_WRITE, 32'h0000_0400, 32'hCAFE_F00D, ac, an, rd);
        txn2(c_CMD_READ,  32'h0000_0000, 32'h0, ac, an, rd);
        chk("alias_hi", rd, 32'hCAFE_F00D);
        txn2(c_CMD_READ,  32'h0000_0403, 32'h0, ac, an, rd);
        chk("alias_lo", rd, 32'hCAFE_F00D);
        txn2(c_CMD_WRITE, 32'h0000_0030, 32'h0000_0001, ac, an, rd);
        chk("rd_hold_on_wr", rd, 32'hCAFE_F00D);
        chk("alias_txn", 32'(b2.txn_cnt), 32'd8);

        // Reset in the middle of a write's WAIT phase
        txn2(c_CMD_WRITE, 32'h0000_0040, 32'h0BAD_C0DE, ac, an, rd);
        @(posedge clk); #1;
        b2.req = 1'b1; b2.cmd = c_CMD_WRITE; b2.addr = 32'h0000_0040; b2.wdata = 32'h5A5A_5A5A;
        @(negedge clk);                     // cycle 0
        @(posedge clk); #1;
        rst2 = 1'b1;                        // cycle 1, in WAIT
        @(posedge clk); #1;
        rst2 = 1'b0; b2.req = 1'b0;
        @(negedge clk);                     // cycle 2
        chk("rstw_c2_ack", 32'(b2.ack),     32'd0);
        chk("rstw_txn",    32'(b2.txn_cnt), 32'd0);
        chk("rstw_rdata",  b2.rdata,        32'd0);
        @(negedge clk);                     // cycle 3: would have been ack
        chk("rstw_c3_ack", 32'(b2.ack),     32'd0);
        txn2(c_CMD_READ, 32'h0000_0040, 32'h0, ac, an, rd);
        chk("rstw_mem",  rd, 32'h0BAD_C0DE);
        chk("rstw_txn1", 32'(b2.txn_cnt), 32'd1);

        // Transaction counter wrap
        @(posedge clk); #1;
        force u_dut0.r_txn_cnt = 16'hFFFF;
        @(negedge clk);
        release u_dut0.r_txn_cnt;
        @(negedge clk);
        chk("wrap_pre", 32'(b0.txn_cnt), 32'h0000_FFFF);
        txn0(c_CMD_WRITE, 32'h0000_000C, 32'h3333_3333, ac, rd);
        chk("wrap_txn",  32'(b0.txn_cnt), 32'd0);
        chk("wrap_rdhold", rd, 32'h2222_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
